// File: rtl/loader_defs.sv
// Shared definitions for the boot-time ROM stream loader.
package loader_defs;

    // Frame parser states, in frame field order: SYNC, LEN_LO, LEN_HI, data, CSUM.
    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    localparam logic [7:0]  SYNC_DEFAULT   = 8'hA5;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam logic [7:0]  CSUM_INIT      = 8'h00;

    // Word count is sent little-endian: low byte first.
    function automatic logic [15:0] frame_len(input logic [7:0] lo, input logic [7:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/loader_word_pack.sv
// Assembles little-endian 32-bit words from a byte stream.
module loader_word_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt_q;
    logic [23:0] lanes_q;

    // The fourth byte completes the word combinationally; the caller registers it.
    always_comb begin
        word_valid = byte_valid && (byte_cnt_q == 2'd3);
        word       = {byte_data, lanes_q};
    end

    // Lane shift register: byte_cnt selects which lane the incoming byte fills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= 2'd0;
            lanes_q    <= 24'd0;
        end else if (clr) begin
            byte_cnt_q <= 2'd0;
            lanes_q    <= 24'd0;
        end else if (byte_valid) begin
            case (byte_cnt_q)
                2'd0:    lanes_q[7:0]   <= byte_data;
                2'd1:    lanes_q[15:8]  <= byte_data;
                2'd2:    lanes_q[23:16] <= byte_data;
                default: lanes_q        <= lanes_q;
            endcase
            byte_cnt_q <= byte_cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/rom_stream_loader.sv
// Boot loader: parses SYNC/LEN/data/CSUM frames, writes instruction ROM, gates core reset.
module rom_stream_loader
    import loader_defs::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    state_e      state_q;
    logic [7:0]  len_lo_q;
    logic [15:0] len_q;
    logic [16:0] word_idx_q;
    logic [7:0]  csum_q;
    logic [31:0] idle_q;

    logic        in_frame;
    logic        timeout_hit;
    logic        last_word;
    logic        is_sync;
    logic [15:0] n_rx;
    logic        pack_valid;
    logic        word_valid;
    logic [31:0] word;

    // Frame decode helpers; the idle counter only runs while a frame is open.
    always_comb begin
        in_frame    = (state_q == StLen0) || (state_q == StLen1) ||
                      (state_q == StData) || (state_q == StCsum);
        timeout_hit = in_frame && !rx_valid && (idle_q == 32'(TIMEOUT_CYC - 1));
        last_word   = (word_idx_q + 17'd1) == {1'b0, len_q};
        is_sync     = (rx_data == SYNC_BYTE);
        n_rx        = frame_len(len_lo_q, rx_data);
        pack_valid  = rx_valid && (state_q == StData);
    end

    // Packer is held clear outside DATA so an aborted frame never leaks a partial word.
    loader_word_pack u_word_pack (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_q != StData),
        .byte_valid (pack_valid),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Frame FSM with registered ROM write port and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            len_lo_q   <= 8'd0;
            len_q      <= 16'd0;
            word_idx_q <= 17'd0;
            csum_q     <= CSUM_INIT;
            idle_q     <= 32'd0;
            rom_we     <= 1'b0;
            rom_waddr  <= '0;
            rom_wdata  <= 32'd0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            rom_we <= 1'b0;
            if (in_frame && !rx_valid) begin
                idle_q <= idle_q + 32'd1;
            end else begin
                idle_q <= 32'd0;
            end

            if (timeout_hit) begin
                // Words already written are left in ROM.
                state_q   <= StErr;
                load_err  <= 1'b1;
                cpu_hold  <= 1'b1;
                load_done <= 1'b0;
            end else if (rx_valid) begin
                case (state_q)
                    StIdle: begin
                        if (is_sync) begin
                            csum_q  <= CSUM_INIT;
                            state_q <= StLen0;
                        end
                    end
                    StLen0: begin
                        len_lo_q <= rx_data;
                        state_q  <= StLen1;
                    end
                    StLen1: begin
                        len_q      <= n_rx;
                        word_idx_q <= 17'd0;
                        if (32'(n_rx) > DEPTH) begin
                            state_q   <= StErr;
                            load_err  <= 1'b1;
                            cpu_hold  <= 1'b1;
                            load_done <= 1'b0;
                        end else if (n_rx == 16'd0) begin
                            state_q <= StCsum;
                        end else begin
                            state_q <= StData;
                        end
                    end
                    StData: begin
                        csum_q <= csum_q ^ rx_data;
                        if (word_valid) begin
                            rom_we     <= 1'b1;
                            rom_waddr  <= word_idx_q[ADDR_W-1:0];
                            rom_wdata  <= word;
                            word_idx_q <= word_idx_q + 17'd1;
                            if (last_word) begin
                                state_q <= StCsum;
                            end
                        end
                    end
                    StCsum: begin
                        if (rx_data == csum_q) begin
                            state_q   <= StDone;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state_q   <= StErr;
                            load_err  <= 1'b1;
                            cpu_hold  <= 1'b1;
                            load_done <= 1'b0;
                        end
                    end
                    StDone: begin
                        if (is_sync) begin
                            cpu_hold  <= 1'b1;
                            load_done <= 1'b0;
                            csum_q    <= CSUM_INIT;
                            state_q   <= StLen0;
                        end
                    end
                    StErr: begin
                        if (is_sync) begin
                            load_err <= 1'b0;
                            csum_q   <= CSUM_INIT;
                            state_q  <= StLen0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
